// File: rtl/ext_uart_bridge.sv
// ext_uart_bridge: byte-wide UART bridge between the core's EXT ports and the board pins.
// RX deserialises 8N1 frames into a one-byte holding register (cd/crda, consumed by cack).
// TX serialises a byte strobed on cq/cwre onto txd while cbsy is high.
module ext_uart_bridge #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] cd,
  output logic       crda,
  input  logic       cack,
  input  logic [7:0] cq,
  input  logic       cwre,
  output logic       cbsy,
  output logic       rx_overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // TX state
  state_t        r_tx_state, w_tx_state_next;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_next;
  logic [2:0]    r_tx_idx, w_tx_idx_next;
  logic [7:0]    r_tx_shift, w_tx_shift_next;
  logic          r_txd, w_txd_next;
  logic          r_cbsy, w_cbsy_next;

  // RX state
  logic          r_rx_meta, r_rs, r_rs_prev;
  state_t        r_rx_state, w_rx_state_next;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_next;
  logic [2:0]    r_rx_idx, w_rx_idx_next;
  logic [7:0]    r_rx_shift, w_rx_shift_next;
  logic [7:0]    r_cd, w_cd_next;
  logic          r_crda, w_crda_next;
  logic          r_overrun, w_overrun_next;
  logic          w_rx_fall;

  assign txd        = r_txd;
  assign cbsy       = r_cbsy;
  assign cd         = r_cd;
  assign crda       = r_crda;
  assign rx_overrun = r_overrun;

  // TX next state: txd and cbsy are computed here so they are registered outputs
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt;
    w_tx_idx_next   = r_tx_idx;
    w_tx_shift_next = r_tx_shift;
    w_txd_next      = r_txd;
    w_cbsy_next     = r_cbsy;
    case (r_tx_state)
      S_IDLE: begin
        if (cwre) begin
          w_tx_shift_next = cq;
          w_tx_cnt_next   = '0;
          w_tx_idx_next   = 3'd0;
          w_txd_next      = 1'b0;
          w_cbsy_next     = 1'b1;
          w_tx_state_next = S_START;
        end
      end
      S_START: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_next   = '0;
          w_txd_next      = r_tx_shift[0];
          w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
          w_tx_state_next = S_DATA;
        end else begin
          w_tx_cnt_next = r_tx_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_next = '0;
          if (r_tx_idx == 3'd7) begin
            w_txd_next      = 1'b1;
            w_tx_state_next = S_STOP;
          end else begin
            w_tx_idx_next   = r_tx_idx + 3'd1;
            w_txd_next      = r_tx_shift[0];
            w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
          end
        end else begin
          w_tx_cnt_next = r_tx_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_next   = '0;
          w_cbsy_next     = 1'b0;
          w_tx_state_next = S_IDLE;
        end else begin
          w_tx_cnt_next = r_tx_cnt + 1'b1;
        end
      end
      default: w_tx_state_next = S_IDLE;
    endcase
  end

  // TX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_txd      <= 1'b1;
      r_cbsy     <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_idx   <= w_tx_idx_next;
      r_tx_shift <= w_tx_shift_next;
      r_txd      <= w_txd_next;
      r_cbsy     <= w_cbsy_next;
    end
  end

  // Two-flop synchroniser on rxd plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rs      <= 1'b1;
      r_rs_prev <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rs      <= r_rx_meta;
      r_rs_prev <= r_rs;
    end
  end

  assign w_rx_fall = r_rs_prev & ~r_rs;

  // RX next state and holding-register handshake; a completing byte wins over cack's clear
  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt;
    w_rx_idx_next   = r_rx_idx;
    w_rx_shift_next = r_rx_shift;
    w_cd_next       = r_cd;
    w_crda_next     = r_crda;
    w_overrun_next  = r_overrun;
    if (cack && r_crda) w_crda_next = 1'b0;
    if (cack) w_overrun_next = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        if (w_rx_fall) begin
          w_rx_cnt_next   = '0;
          w_rx_state_next = S_START;
        end
      end
      S_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_next   = '0;
          w_rx_idx_next   = 3'd0;
          w_rx_state_next = r_rs ? S_IDLE : S_DATA;
        end else begin
          w_rx_cnt_next = r_rx_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_next   = '0;
          w_rx_shift_next = {r_rs, r_rx_shift[7:1]};
          if (r_rx_idx == 3'd7) w_rx_state_next = S_STOP;
          else                  w_rx_idx_next   = r_rx_idx + 3'd1;
        end else begin
          w_rx_cnt_next = r_rx_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_next   = '0;
          w_rx_state_next = S_IDLE;
          if (r_rs) begin
            if (!r_crda || cack) begin
              w_cd_next   = r_rx_shift;
              w_crda_next = 1'b1;
            end else begin
              w_overrun_next = 1'b1;
            end
          end
        end else begin
          w_rx_cnt_next = r_rx_cnt + 1'b1;
        end
      end
      default: w_rx_state_next = S_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_cd       <= 8'h00;
      r_crda     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_rx_idx   <= w_rx_idx_next;
      r_rx_shift <= w_rx_shift_next;
      r_cd       <= w_cd_next;
      r_crda     <= w_crda_next;
      r_overrun  <= w_overrun_next;
    end
  end

endmodule

// File: tb/tb_ext_uart_bridge.sv
// tb_ext_uart_bridge: directed bench for ext_uart_bridge with CLKS_PER_BIT=4.
module tb_ext_uart_bridge;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       cack = 1'b0;
  logic       cwre = 1'b0;
  logic [7:0] cq = 8'h00;
  logic       rxd_w;
  logic       txd, crda, cbsy, rx_overrun;
  logic [7:0] cd;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] lb_bytes [4] = '{8'hA7, 8'h3C, 8'h00, 8'hFF};

  assign rxd_w = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  ext_uart_bridge #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .reset(reset), .rxd(rxd_w), .txd(txd), .cd(cd), .crda(crda),
    .cack(cack), .cq(cq), .cwre(cwre), .cbsy(cbsy), .rx_overrun(rx_overrun)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // send byte b, check every txd cycle; optionally strobe cwre(0x55) at cycle inject
  task automatic send_tx(input logic [7:0] b, input int inject);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    cq = b; cwre = 1'b1;
    tick(1);
    cwre = 1'b0;
    for (int k = 0; k < 10 * N; k++) begin
      chk1($sformatf("tx_%02h_txd_bit%0d_c%0d", b, k / N, k % N), txd, frame[0]);
      chk1($sformatf("tx_%02h_cbsy_c%0d", b, k), cbsy, 1'b1);
      if (k == inject) begin cq = 8'h55; cwre = 1'b1; end
      else cwre = 1'b0;
      if (k % N == N - 1) frame = frame >> 1;
      tick(1);
    end
    cwre = 1'b0;
    chk1($sformatf("tx_%02h_cbsy_fall", b), cbsy, 1'b0);
    chk1($sformatf("tx_%02h_txd_idle", b), txd, 1'b1);
  endtask

  // drive one 8N1 frame on rxd; returns just after the 10th bit period ends
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int p = 0; p < 10; p++) begin
      rxd_drv = f[0];
      f = f >> 1;
      tick(N);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic pulse_cack();
    cack = 1'b1;
    tick(1);
    cack = 1'b0;
  endtask

  initial begin
    int w;
    // reset state, asserted asynchronously between edges
    #2 reset = 1'b0;
    #1;
    chk1("rst_txd", txd, 1'b1);
    chk1("rst_cbsy", cbsy, 1'b0);
    chk1("rst_crda", crda, 1'b0);
    chk8("rst_cd", cd, 8'h00);
    chk1("rst_ovr", rx_overrun, 1'b0);
    tick(3);
    reset = 1'b1;
    tick(3);

    // TX of 0x42
    send_tx(8'h42, -1);

    // RX 0x41, hold without cack, then consume
    chk1("rx41_crda_before", crda, 1'b0);
    rx_frame(8'h41, 1'b1);
    tick(2);
    chk1("rx41_crda", crda, 1'b1);
    chk8("rx41_cd", cd, 8'h41);
    chk1("rx41_ovr", rx_overrun, 1'b0);
    tick(20);
    chk1("rx41_crda_hold", crda, 1'b1);
    chk8("rx41_cd_hold", cd, 8'h41);
    pulse_cack();
    chk1("rx41_crda_cleared", crda, 1'b0);
    chk8("rx41_cd_kept", cd, 8'h41);
    pulse_cack();
    chk1("cack_idle_ignored", crda, 1'b0);
    tick(2);

    // overrun: 0x31 then 0x32 with no cack
    rx_frame(8'h31, 1'b1);
    tick(2);
    chk8("rx31_cd", cd, 8'h31);
    chk1("rx31_crda", crda, 1'b1);
    rx_frame(8'h32, 1'b1);
    tick(2);
    chk8("rx32_cd_unchanged", cd, 8'h31);
    chk1("rx32_ovr", rx_overrun, 1'b1);
    chk1("rx32_crda", crda, 1'b1);
    pulse_cack();
    chk1("ovr_cack_crda", crda, 1'b0);
    chk1("ovr_cack_ovr", rx_overrun, 1'b0);
    rx_frame(8'h33, 1'b1);
    tick(2);
    chk8("rx33_cd", cd, 8'h33);
    chk1("rx33_crda", crda, 1'b1);

    // cack in the same cycle a new byte completes: new byte loads, no overrun
    rx_frame(8'h34, 1'b1);
    cack = 1'b1;
    tick(1);
    cack = 1'b0;
    chk8("same_cycle_cd", cd, 8'h34);
    chk1("same_cycle_crda", crda, 1'b1);
    chk1("same_cycle_ovr", rx_overrun, 1'b0);
    tick(2);
    pulse_cack();
    chk1("same_cycle_consumed", crda, 1'b0);

    // false start: one-cycle low pulse
    rxd_drv = 1'b0;
    tick(1);
    rxd_drv = 1'b1;
    tick(60);
    chk1("false_start_crda", crda, 1'b0);
    // framing error: stop bit low
    rx_frame(8'hA5, 1'b0);
    tick(10);
    chk1("frame_err_crda", crda, 1'b0);
    chk1("frame_err_ovr", rx_overrun, 1'b0);
    chk8("frame_err_cd", cd, 8'h34);

    // reset mid-operation: holding register full, overrun set, TX and RX frames in flight
    rx_frame(8'h36, 1'b1);
    tick(2);
    rx_frame(8'h37, 1'b1);
    tick(2);
    chk1("pre_rst_ovr", rx_overrun, 1'b1);
    chk8("pre_rst_cd", cd, 8'h36);
    cq = 8'hC3; cwre = 1'b1;
    tick(1);
    cwre = 1'b0;
    rxd_drv = 1'b0;
    tick(6);
    chk1("pre_rst_cbsy", cbsy, 1'b1);
    #3 reset = 1'b0;
    #1;
    chk1("mid_rst_txd", txd, 1'b1);
    chk1("mid_rst_cbsy", cbsy, 1'b0);
    chk1("mid_rst_crda", crda, 1'b0);
    chk8("mid_rst_cd", cd, 8'h00);
    chk1("mid_rst_ovr", rx_overrun, 1'b0);
    tick(2);
    rxd_drv = 1'b1;
    reset = 1'b1;
    tick(5);

    // cwre while busy is ignored
    send_tx(8'h42, 12);
    tick(2);

    // loopback
    loop_en = 1'b1;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      cq = lb_bytes[i]; cwre = 1'b1;
      tick(1);
      cwre = 1'b0;
      w = 0;
      while (!crda && w < 200) begin tick(1); w++; end
      chk1($sformatf("lb%0d_crda_in_time", i), crda, 1'b1);
      chk8($sformatf("lb%0d_cd", i), cd, lb_bytes[i]);
      pulse_cack();
      chk1($sformatf("lb%0d_crda_cleared", i), crda, 1'b0);
      w = 0;
      while (cbsy && w < 200) begin tick(1); w++; end
      chk1($sformatf("lb%0d_cbsy_idle", i), cbsy, 1'b0);
      tick(3);
    end
    chk1("lb_no_overrun", rx_overrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
